pulse_width_meter: RTL and testbench
====================================

# pulse_width_meter

Measures the high time of a synchronized digital input in clock cycles and delivers each result over a valid/ready handshake. It is the inverse of the team's cycle timer: the timer turns a programmed count into an event, and this block turns an observed event into a count. It sits downstream of the debouncer and edge-detector chain, on signals that are already synchronized to `clk`.

## Interface
- `MAX_COUNT`, default 255: saturation value of the measurement. Counter width is `W = $clog2(MAX_COUNT+1)`, which is 8 bits at the default.
- `clk` input, 1 bit: single clock. All logic is rising-edge.
- `reset_n` input, 1 bit: synchronous, active-low reset, sampled on the `clk` rising edge.
- `enable` input, 1 bit: arms the meter. When low, the meter returns to IDLE.
- `sig_in` input, 1 bit: signal under measurement. It is already synchronous to `clk`.
- `meas_ready` input, 1 bit: consumer accepts the current result.
- `meas_valid` output, 1 bit: a result is pending.
- `meas_width` output, W bits: measured high time in cycles.
- `meas_overflow` output, 1 bit: the pulse exceeded `MAX_COUNT`, so `meas_width` is saturated.
- `meas_missed` output, 1 bit: one or more rising edges arrived while a result was pending and were dropped.
- `busy` output, 1 bit: high while in the MEASURE state.

## Operation
- Internal registers: `sig_d`, the previous value of `sig_in`; `cnt`, W bits; `ovf`; `state`.
- Rising edge is defined as `sig_in & ~sig_d`.
- States: IDLE, ARM, WAIT_RISE, MEASURE, HOLD.
- IDLE:
  - If `enable` is high, go to ARM.
- ARM:
  - If `sig_in` is 0, go to WAIT_RISE.
  - This guarantees that a pulse already in progress when the meter is armed is never measured.
- WAIT_RISE:
  - On `sig_in`=1, load `cnt<=1`, clear `ovf`, and go to MEASURE.
- MEASURE, while `sig_in`=1:
  - If `cnt<MAX_COUNT`, increment `cnt`.
  - If `cnt==MAX_COUNT`, hold `cnt` and set `ovf<=1`.
- MEASURE, on `sig_in`=0:
  - Load `meas_width<=cnt` and `meas_overflow<=ovf`.
  - Set `meas_valid<=1` and go to HOLD.
- HOLD:
  - Output registers stay frozen.
  - Any rising edge sets `meas_missed<=1`. This flag is sticky.
  - If `meas_valid & meas_ready`:
    - Clear `meas_valid` and `meas_missed`.
    - If `enable` is 1, go to ARM; otherwise go to IDLE.
- Effect of `enable`=0:
  - In ARM, WAIT_RISE or MEASURE, go to IDLE next cycle and discard `cnt`. No result is produced.
  - In HOLD, it has no effect; the pending result must still be consumed.
- A handshake on the same edge as a new rising edge: that edge is not counted. The block re-enters ARM and waits for a low sample.
- `meas_width`, `meas_overflow` and `meas_missed` are only meaningful while `meas_valid` is 1. `meas_width` and `meas_overflow` hold their last values after the handshake.
- Arithmetic is unsigned W-bit. `cnt` never wraps.

## Timing
- Reset (`reset_n`=0 at an edge):
  - `state=IDLE`.
  - `sig_d`, `cnt` and `ovf` are 0.
  - All outputs are 0.
  - Reset takes priority over every other condition, including mid-MEASURE and mid-HOLD. Any pending result is lost.
- Measurement timing:
  - `sig_in` is sampled high at edges t .. t+N-1 and low at t+N, with the block in WAIT_RISE at edge t.
  - `meas_valid` rises after edge t+N, with `meas_width=N`.
  - Latency is one cycle from the first low sample.
- `busy` goes high after edge t and low after edge t+N.
- `meas_valid` falls the cycle after the edge where `meas_valid & meas_ready`. `meas_ready` may be held high permanently.
- Minimum cycle from handshake to the next measurement start:
  - handshake edge, then ARM (one cycle, `sig_in` low), then WAIT_RISE, then the rising sample.
- Saturation: a pulse of N ≥ `MAX_COUNT`+1 cycles reports `MAX_COUNT` with `meas_overflow=1`.
- Exact-fit pulse: N = `MAX_COUNT` reports `MAX_COUNT` with `meas_overflow=0`.

## Test plan
- Basic pulse:
  - Stimulus: reset, then `enable`=1 and `meas_ready`=1, then `sig_in` low for 3 cycles, high for 5, then low.
  - Required: `meas_valid` pulses for one cycle with `meas_width=5`, `meas_overflow=0`, `meas_missed=0`.
- Minimum and saturation (`MAX_COUNT`=255):
  - A 1-cycle pulse gives width 1.
  - A 255-cycle pulse gives 255 with `meas_overflow=0`.
  - A 300-cycle pulse gives 255 with `meas_overflow=1`.
- Backpressure:
  - Stimulus: `meas_ready`=0, a 4-cycle pulse, then two more pulses, then `meas_ready`=1 after 20 cycles.
  - Required: `meas_width` stays at 4 throughout with `meas_missed=1`.
  - After the handshake, `meas_valid` and `meas_missed` are 0.
  - The next pulse measures correctly.
- Armed mid-pulse:
  - Stimulus: `sig_in` already high when `enable` rises, staying high for 10 more cycles.
  - Required: no result. A following 6-cycle pulse reports 6.
- Abort:
  - Case 1: `enable` drops during the 3rd cycle of a pulse. Required: no `meas_valid` and `state=IDLE`.
  - Case 2: `enable` drops while in HOLD. Required: the result stays valid until the handshake.
- Reset mid-operation:
  - Stimulus: `reset_n`=0 for one edge during MEASURE, and again during HOLD.
  - Required: after that edge all outputs are 0, `busy`=0, and the block is in IDLE.

Source files
------------

// File: rtl/pulse_width_meter_if.sv
// Result handshake carried from pulse_width_meter (master) to its consumer (slave).
interface pulse_width_meter_if #(
  parameter int MAX_COUNT = 255
);
  localparam int W = $clog2(MAX_COUNT + 1);

  logic         meas_valid;
  logic         meas_ready;
  logic [W-1:0] meas_width;
  logic         meas_overflow;
  logic         meas_missed;

  modport master (
    output meas_valid, meas_width, meas_overflow, meas_missed,
    input  meas_ready
  );

  modport slave (
    input  meas_valid, meas_width, meas_overflow, meas_missed,
    output meas_ready
  );
endinterface

// File: rtl/pulse_width_meter.sv
// Measures the high time of a clk-synchronous input in cycles and hands each
// result to a consumer over a valid/ready handshake.
module pulse_width_meter #(
  parameter int MAX_COUNT = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                sig_in,
  output logic                busy,
  pulse_width_meter_if.master meas
);
  localparam int W = $clog2(MAX_COUNT + 1);
  localparam logic [W-1:0] MAX_W = W'(MAX_COUNT);

  typedef enum logic [2:0] {IDLE, ARM, WAIT_RISE, MEASURE, HOLD} state_e;

  state_e       state_q, state_d;
  logic         sig_prev_q;
  logic [W-1:0] cnt_q, cnt_d;
  logic         ovf_q, ovf_d;
  logic         valid_q, valid_d;
  logic [W-1:0] width_q, width_d;
  logic         ovf_out_q, ovf_out_d;
  logic         missed_q, missed_d;
  logic         rise;

  // Counter never wraps: it sticks at MAX_COUNT once reached.
  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] c);
    return (c == MAX_W) ? c : c + 1'b1;
  endfunction

  assign rise = sig_in & ~sig_prev_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    valid_d   = valid_q;
    width_d   = width_q;
    ovf_out_d = ovf_out_q;
    missed_d  = missed_q;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = ARM;
      end
      ARM: begin
        if (!enable)      state_d = IDLE;
        else if (!sig_in) state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (sig_in) begin
          cnt_d   = W'(1);
          ovf_d   = 1'b0;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (sig_in) begin
          cnt_d = sat_inc(cnt_q);
          ovf_d = ovf_q | (cnt_q == MAX_W);
        end else begin
          width_d   = cnt_q;
          ovf_out_d = ovf_q;
          valid_d   = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (rise) missed_d = 1'b1;
        // A rise coinciding with the handshake is dropped, not flagged.
        if (valid_q && meas.meas_ready) begin
          valid_d  = 1'b0;
          missed_d = 1'b0;
          state_d  = enable ? ARM : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sig_prev_q <= 1'b0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      width_q    <= '0;
      ovf_out_q  <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sig_prev_q <= sig_in;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
      width_q    <= width_d;
      ovf_out_q  <= ovf_out_d;
      missed_q   <= missed_d;
    end
  end

  assign busy               = (state_q == MEASURE);
  assign meas.meas_valid    = valid_q;
  assign meas.meas_width    = width_q;
  assign meas.meas_overflow = ovf_out_q;
  assign meas.meas_missed   = missed_q;
endmodule

// File: tb/tb_pulse_width_meter.sv
// Bench for pulse_width_meter: expected results come from the pulse lengths
// driven (min(N, MAX_COUNT), overflow when N > MAX_COUNT) and scenario rules.
module tb_pulse_width_meter;
  localparam int MAX_COUNT = 255;

  logic clk = 1'b0;
  logic reset_n;
  logic enable;
  logic sig_in;
  logic busy;

  pulse_width_meter_if #(.MAX_COUNT(MAX_COUNT)) meas_if ();

  pulse_width_meter #(.MAX_COUNT(MAX_COUNT)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .sig_in (sig_in),
    .busy   (busy),
    .meas   (meas_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w;
    int o;
    int m;
  } res_t;

  res_t got_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Record every completed handshake; the next rising edge consumes it.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && meas_if.meas_valid === 1'b1 && meas_if.meas_ready === 1'b1) begin
      res_t r;
      r.w = int'(meas_if.meas_width);
      r.o = int'(meas_if.meas_overflow);
      r.m = int'(meas_if.meas_missed);
      got_q.push_back(r);
    end
  end

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int lo, input int hi);
    sig_in = 1'b0;
    cyc(lo);
    sig_in = 1'b1;
    cyc(hi);
    sig_in = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk_eq({tag, "_valid"}, int'(meas_if.meas_valid), 0);
    chk_eq({tag, "_width"}, int'(meas_if.meas_width), 0);
    chk_eq({tag, "_ovf"}, int'(meas_if.meas_overflow), 0);
    chk_eq({tag, "_missed"}, int'(meas_if.meas_missed), 0);
    chk_eq({tag, "_busy"}, int'(busy), 0);
  endtask

  // Wait for a result, optionally hold ready low for dly cycles, then check it.
  task automatic expect_result(input string tag, input int w, input int o, input int m, input int dly);
    int   n;
    logic rdy0;
    res_t r;
    rdy0 = meas_if.meas_ready;
    n = 0;
    while (got_q.size() == 0 && meas_if.meas_valid !== 1'b1 && n < 400) begin
      cyc(1);
      n++;
    end
    if (got_q.size() == 0 && meas_if.meas_valid === 1'b1) begin
      cyc(dly);
      meas_if.meas_ready = 1'b1;
      n = 0;
      while (got_q.size() == 0 && n < 4) begin
        cyc(1);
        n++;
      end
    end
    meas_if.meas_ready = rdy0;
    if (got_q.size() == 0) begin
      chk_eq({tag, "_timeout"}, 0, 1);
    end else begin
      r = got_q.pop_front();
      chk_eq({tag, "_width"}, r.w, w);
      chk_eq({tag, "_ovf"}, r.o, o);
      chk_eq({tag, "_missed"}, r.m, m);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    sig_in  = 1'b0;
    meas_if.meas_ready = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    chk_outputs_zero("reset");

    // Basic pulse: one-cycle valid with ready held high.
    enable = 1'b1;
    meas_if.meas_ready = 1'b1;
    pulse(3, 5);
    chk_eq("basic_busy", int'(busy), 1);
    cyc(1);
    chk_eq("basic_valid", int'(meas_if.meas_valid), 1);
    chk_eq("basic_width", int'(meas_if.meas_width), 5);
    chk_eq("basic_ovf", int'(meas_if.meas_overflow), 0);
    chk_eq("basic_missed", int'(meas_if.meas_missed), 0);
    chk_eq("basic_busy_lo", int'(busy), 0);
    cyc(1);
    chk_eq("basic_valid_drop", int'(meas_if.meas_valid), 0);
    expect_result("basic_q", 5, 0, 0, 0);

    // Minimum width and saturation boundaries.
    pulse(4, 1);
    expect_result("min1", 1, 0, 0, 0);
    pulse(4, 254);
    expect_result("p254", 254, 0, 0, 0);
    pulse(4, 255);
    expect_result("p255", 255, 0, 0, 0);
    pulse(4, 256);
    expect_result("p256", 255, 1, 0, 0);
    pulse(4, 300);
    expect_result("p300", 255, 1, 0, 0);

    // Randomized pulses with random consumer delay.
    meas_if.meas_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      int lo, hi, d;
      lo = $urandom_range(1, 6);
      hi = ($urandom_range(0, 7) == 0) ? $urandom_range(250, 300) : $urandom_range(1, 30);
      d  = $urandom_range(0, 4);
      pulse(lo, hi);
      expect_result($sformatf("rnd%0d", i), (hi > MAX_COUNT) ? MAX_COUNT : hi,
                    (hi > MAX_COUNT) ? 1 : 0, 0, d);
    end

    // Backpressure: extra pulses while holding are dropped and flagged.
    meas_if.meas_ready = 1'b0;
    pulse(3, 4);
    cyc(1);
    chk_eq("bp_valid", int'(meas_if.meas_valid), 1);
    chk_eq("bp_width0", int'(meas_if.meas_width), 4);
    chk_eq("bp_missed0", int'(meas_if.meas_missed), 0);
    pulse(3, 2);
    chk_eq("bp_width1", int'(meas_if.meas_width), 4);
    chk_eq("bp_missed1", int'(meas_if.meas_missed), 1);
    pulse(3, 2);
    cyc(9);
    chk_eq("bp_width2", int'(meas_if.meas_width), 4);
    chk_eq("bp_missed2", int'(meas_if.meas_missed), 1);
    chk_eq("bp_valid2", int'(meas_if.meas_valid), 1);
    expect_result("bp", 4, 0, 1, 0);
    chk_eq("bp_valid_after", int'(meas_if.meas_valid), 0);
    chk_eq("bp_missed_after", int'(meas_if.meas_missed), 0);
    meas_if.meas_ready = 1'b1;
    pulse(3, 7);
    expect_result("bp_next", 7, 0, 0, 0);

    // Armed while the input is already high: that pulse is ignored.
    enable = 1'b0;
    cyc(2);
    sig_in = 1'b1;
    cyc(2);
    enable = 1'b1;
    cyc(10);
    sig_in = 1'b0;
    cyc(6);
    chk_eq("midpulse_none", got_q.size(), 0);
    chk_eq("midpulse_valid", int'(meas_if.meas_valid), 0);
    pulse(3, 6);
    expect_result("midpulse_next", 6, 0, 0, 0);

    // Abort during measurement.
    sig_in = 1'b0;
    cyc(3);
    sig_in = 1'b1;
    cyc(2);
    chk_eq("abort1_busy", int'(busy), 1);
    enable = 1'b0;
    cyc(1);
    chk_eq("abort1_busy_lo", int'(busy), 0);
    cyc(2);
    sig_in = 1'b0;
    cyc(5);
    chk_eq("abort1_valid", int'(meas_if.meas_valid), 0);
    chk_eq("abort1_none", got_q.size(), 0);
    pulse(3, 4);
    cyc(5);
    chk_eq("abort1_idle", got_q.size(), 0);

    // Disable while holding: result survives until consumed.
    enable = 1'b1;
    meas_if.meas_ready = 1'b0;
    cyc(1);
    pulse(3, 5);
    cyc(1);
    chk_eq("abort2_valid", int'(meas_if.meas_valid), 1);
    enable = 1'b0;
    cyc(5);
    chk_eq("abort2_hold_valid", int'(meas_if.meas_valid), 1);
    chk_eq("abort2_hold_width", int'(meas_if.meas_width), 5);
    expect_result("abort2", 5, 0, 0, 0);
    pulse(3, 4);
    cyc(5);
    chk_eq("abort2_idle_valid", int'(meas_if.meas_valid), 0);
    chk_eq("abort2_idle_none", got_q.size(), 0);

    // Reset during MEASURE.
    enable = 1'b1;
    meas_if.meas_ready = 1'b1;
    cyc(1);
    pulse(3, 4);
    sig_in = 1'b1;
    chk_eq("rstm_busy", int'(busy), 1);
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    chk_outputs_zero("rst_meas");
    cyc(3);
    sig_in = 1'b0;
    cyc(5);
    chk_eq("rst_meas_none", got_q.size(), 0);

    // Reset during HOLD.
    meas_if.meas_ready = 1'b0;
    pulse(3, 6);
    cyc(1);
    chk_eq("rsth_valid", int'(meas_if.meas_valid), 1);
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    chk_outputs_zero("rst_hold");
    meas_if.meas_ready = 1'b1;
    cyc(6);
    chk_eq("rst_hold_none", got_q.size(), 0);
    pulse(3, 9);
    expect_result("post_reset", 9, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
